// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM-stage CPU port and an external port, with a
// starvation guard. Optional stall statistics are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int EXT_BURST = 2,
  parameter int WAIT_W    = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic [31:0]       ext_rdata,
  output logic              ext_valid,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              arb_state
`ifdef DMEM_ARB_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Handshake: ext_req is held by the requester until ext_gnt is seen high in a
  // cycle; that cycle performs the access. cpu_req is retried while cpu_stall=1.

  typedef enum logic {
    S_CPU = 1'b0,
    S_EXT = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W:0]   WAIT_LIM  = (WAIT_W + 1)'(MAX_WAIT);
  localparam logic [WAIT_W:0]   BURST_LIM = (WAIT_W + 1)'(EXT_BURST);

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   burst_cnt;
  logic                cpu_gnt;
  logic                ext_denied;
  logic                ext_rd_gnt;
  logic [WAIT_W:0]     wait_inc;
  logic [WAIT_W:0]     burst_inc;

  assign arb_state = state;

  always_comb begin
    cpu_gnt   = 1'b0;
    ext_gnt   = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (state == S_CPU) begin
      cpu_gnt = cpu_req;
      ext_gnt = ext_req & ~cpu_req;
    end else begin
      ext_gnt = ext_req;
      cpu_gnt = cpu_req & ~ext_req;
    end
    if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we;
    end else if (cpu_gnt) begin
      mem_we = cpu_we;
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rdata  = mem_rdata;
  assign ext_denied = ext_req & ~ext_gnt;
  assign ext_rd_gnt = ext_gnt & ~ext_we;
  assign wait_inc   = {1'b0, wait_cnt} + (WAIT_W + 1)'(1);
  assign burst_inc  = {1'b0, burst_cnt} + (WAIT_W + 1)'(1);

  // The switch fires on the edge that ends the MAX_WAIT-th denied cycle, so the
  // CPU wins exactly MAX_WAIT conflicting cycles before the external burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CPU;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      ext_valid <= 1'b0;
      ext_rdata <= '0;
    end else begin
      ext_valid <= ext_rd_gnt;
      if (ext_rd_gnt) ext_rdata <= mem_rdata;

      if (ext_gnt) wait_cnt <= '0;
      else if (ext_denied && wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + WAIT_W'(1);

      case (state)
        S_CPU: begin
          if (ext_denied && wait_inc >= WAIT_LIM) begin
            state     <= S_EXT;
            burst_cnt <= '0;
          end
        end
        S_EXT: begin
          if (ext_gnt) burst_cnt <= burst_cnt + WAIT_W'(1);
          if (!ext_req || burst_inc >= BURST_LIM) state <= S_CPU;
        end
        default: state <= S_CPU;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (cpu_stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
